// File: rtl/memif_pkg.sv
// -----------------------------------------------------------------------------
// memif_pkg
// Shared definitions for the memory access stage of the multicycle core:
//   - default word / address widths
//   - FSM state encoding (IDLE, REQ, DONE)
//   - read destination encoding (DEST_IR, DEST_MDR)
// Optional feature macro used by importers: MEMIF_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package memif_pkg;

    localparam int MEMIF_DATA_W = 16;
    localparam int MEMIF_ADDR_W = 12;

    // Access FSM state encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Which register an acknowledged read lands in.
    localparam logic DEST_MDR = 1'b0;
    localparam logic DEST_IR  = 1'b1;

endpackage

// File: rtl/memif_watchdog.sv
// -----------------------------------------------------------------------------
// memif_watchdog
// Counts REQ cycles that pass without an acknowledge and flags expiry on the
// cycle where the TIMEOUT_CYCLES-th unacknowledged REQ cycle is being spent.
// Only instantiated when MEMIF_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : entering REQ this cycle (clears the counter)
//   active    : FSM is in REQ
//   ack       : memory acknowledge
//   expire    : abort the current request at the next edge
// -----------------------------------------------------------------------------
module memif_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expire
);

    // At least 8 bits, wider if the limit needs it.
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt <= '0;
        end else if (active && !ack) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt holds the number of REQ cycles already elapsed, so the current
    // cycle is number cnt+1.
    assign expire = active && !ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-side stage below the multicycle control unit. Converts the MemRead /
// MemWrite / IorD / IRWrite strobes into a req/ack transaction on a
// variable-latency memory port, captures read data into IR or MDR, and stalls
// the control unit through busy_o until the access completes.
// Optional feature: define MEMIF_TIMEOUT_EN to abort requests that are not
// acknowledged within TIMEOUT_CYCLES REQ cycles (sticky err_o).
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   mem_read_i, mem_write_i    : access strobes (write wins if both set)
//   iord_i                     : address select, 0 = pc_i, 1 = addr_i
//   ir_write_i                 : read lands in IR instead of MDR
//   pc_i, addr_i, wdata_i      : address sources and store data
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o    : memory request side (held until ack)
//   mem_rdata_i, mem_ack_i     : memory response side
//   ir_o, mdr_o                : instruction / memory data registers
//   busy_o                     : stall to control unit
//   err_o                      : sticky timeout flag (0 without the feature)
// -----------------------------------------------------------------------------
module mem_access_unit
    import memif_pkg::*;
#(
    parameter int DATA_W         = MEMIF_DATA_W,
    parameter int ADDR_W         = MEMIF_ADDR_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              iord_i,
    input  logic              ir_write_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [DATA_W-1:0] ir_o,
    output logic [DATA_W-1:0] mdr_o,
    output logic              busy_o,
    output logic              err_o
);

    logic [1:0] state;
    logic       dest;
    logic       cmd;
    logic       start;
    logic       timeout;

    assign cmd   = mem_read_i | mem_write_i;
    assign start = (state == IDLE) && cmd;

    // Combinational in IDLE so the control unit stalls in the very cycle it
    // issues the command; DONE releases it.
    always_comb begin
        busy_o = 1'b0;
        case (state)
            IDLE:    busy_o = cmd;
            REQ:     busy_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

`ifdef MEMIF_TIMEOUT_EN
    logic err_q;

    memif_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .active (state == REQ),
        .ack    (mem_ack_i),
        .expire (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dest        <= DEST_MDR;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            ir_o        <= '0;
            mdr_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd) begin
                        state       <= REQ;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= mem_write_i;
                        mem_addr_o  <= iord_i ? addr_i : pc_i;
                        mem_wdata_o <= wdata_i;
                        // A simultaneous write turns the access into a
                        // store, so IRWrite must not redirect anything.
                        dest        <= (ir_write_i && !mem_write_i) ? DEST_IR : DEST_MDR;
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        state     <= DONE;
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            if (dest == DEST_IR) begin
                                ir_o <= mem_rdata_i;
                            end else begin
                                mdr_o <= mem_rdata_i;
                            end
                        end
                    end else if (timeout) begin
                        state     <= DONE;
                        mem_req_o <= 1'b0;
                    end
                end
                // The control unit still shows the strobes of the state it
                // is leaving; ignore them for one cycle.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i, iord_i, ir_write_i;
    logic [11:0] pc_i, addr_i;
    logic [15:0] wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [11:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [15:0] ir_o, mdr_o;
    logic        busy_o, err_o;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DATA_W(16), .ADDR_W(12), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .iord_i(iord_i), .ir_write_i(ir_write_i),
        .pc_i(pc_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .ir_o(ir_o), .mdr_o(mdr_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        string       name;
        bit          rd, wr, iord, irw;
        logic [11:0] pc, addr;
        logic [15:0] wdata, rdata;
        int          delay;      // unacked REQ cycles before ack
        logic [11:0] exp_addr;
        bit          exp_we;
        logic [15:0] exp_wdata, exp_ir, exp_mdr;
        int          exp_busy;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(string nm, bit rd, bit wr, bit iord, bit irw,
                                logic [11:0] pc, logic [11:0] addr,
                                logic [15:0] wdata, logic [15:0] rdata, int delay,
                                logic [11:0] ea, bit ewe, logic [15:0] ewd,
                                logic [15:0] eir, logic [15:0] emdr, int ebusy);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.iord = iord; v.irw = irw;
        v.pc = pc; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
        v.exp_addr = ea; v.exp_we = ewe; v.exp_wdata = ewd;
        v.exp_ir = eir; v.exp_mdr = emdr; v.exp_busy = ebusy;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_read_i = 0; mem_write_i = 0; iord_i = 0; ir_write_i = 0;
        pc_i = '0; addr_i = '0; wdata_i = '0;
    endtask

    // Issue one command, act as memory, hold strobes through DONE, then
    // confirm no second transaction follows.
    task automatic run_vec(input vec_t v);
        int busy_cnt = 0;
        int req_cnt  = 0;
        int txn_cnt  = 0;
        bit prev_req = 0;
        bit seen     = 0;
        bit done     = 0;
        @(posedge clk); #1;
        mem_read_i = v.rd; mem_write_i = v.wr; iord_i = v.iord; ir_write_i = v.irw;
        pc_i = v.pc; addr_i = v.addr; wdata_i = v.wdata;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            mem_ack_i = 0;
            if (busy_o) busy_cnt++;
            if (mem_req_o && !prev_req) begin
                txn_cnt++;
                if (!seen) begin
                    check({v.name, ".addr"},  32'(mem_addr_o),  32'(v.exp_addr));
                    check({v.name, ".we"},    32'(mem_we_o),    32'(v.exp_we));
                    check({v.name, ".wdata"}, 32'(mem_wdata_o), 32'(v.exp_wdata));
                end
                seen = 1;
            end
            prev_req = mem_req_o;
            if (mem_req_o) begin
                if (req_cnt == v.delay) begin
                    mem_ack_i   = 1;
                    mem_rdata_i = v.rdata;
                end
                req_cnt++;
            end
            if (seen && !mem_req_o && !busy_o) done = 1;
        end
        check({v.name, ".completed"}, 32'(done), 32'd1);
        check({v.name, ".busy_cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
        check({v.name, ".ir"},  32'(ir_o),  32'(v.exp_ir));
        check({v.name, ".mdr"}, 32'(mdr_o), 32'(v.exp_mdr));
        // Strobes stay up for the whole DONE cycle, drop once back in IDLE.
        @(posedge clk); #1;
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_req_o && !prev_req) txn_cnt++;
            prev_req = mem_req_o;
        end
        check({v.name, ".txn_count"}, 32'(txn_cnt), 32'd1);
        check({v.name, ".err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        vecs[0] = mk("fetch",      1,0,0,1, 12'h010,12'h003, 16'h0000,16'h8003, 0,
                     12'h010,0,16'h0000, 16'h8003,16'h0000, 2);
        vecs[1] = mk("load",       1,0,1,0, 12'h011,12'h0A5, 16'h5555,16'h1234, 3,
                     12'h0A5,0,16'h5555, 16'h8003,16'h1234, 5);
        vecs[2] = mk("store_conf", 1,1,1,1, 12'h012,12'h0FF, 16'hBEEF,16'hDEAD, 1,
                     12'h0FF,1,16'hBEEF, 16'h8003,16'h1234, 3);
        vecs[3] = mk("fetch_iord", 1,0,1,1, 12'h020,12'h7FF, 16'h0000,16'hA5A5, 2,
                     12'h7FF,0,16'h0000, 16'hA5A5,16'h1234, 4);
        vecs[4] = mk("load_pc",    1,0,0,0, 12'hFFF,12'h001, 16'h0000,16'hFFFF, 0,
                     12'hFFF,0,16'h0000, 16'hA5A5,16'hFFFF, 2);
        vecs[5] = mk("store",      0,1,0,1, 12'h123,12'h456, 16'h0001,16'h7777, 0,
                     12'h123,1,16'h0001, 16'hA5A5,16'hFFFF, 2);

        clear_inputs();
        mem_ack_i = 0; mem_rdata_i = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Idle after reset: every output at zero.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("reset_idle",
                  {mem_req_o, mem_we_o, busy_o, err_o, 4'h0, 24'h0} |
                  32'(mem_addr_o) | 32'(mem_wdata_o) | 32'(ir_o) | 32'(mdr_o), 32'd0);
        end

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Spurious ack in IDLE must be ignored.
        @(posedge clk); #1;
        mem_ack_i = 1; mem_rdata_i = 16'h9999;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_ack_i = 0;
        check("spur_ack.ir",  32'(ir_o),  32'hA5A5);
        check("spur_ack.mdr", 32'(mdr_o), 32'hFFFF);
        check("spur_ack.req", 32'({mem_req_o, busy_o}), 32'd0);

        // IRWrite alone is not a command.
        @(posedge clk); #1;
        ir_write_i = 1;
        @(negedge clk);
        check("irw_only.busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("irw_only.req", 32'(mem_req_o), 32'd0);
        @(posedge clk); #1;
        clear_inputs();

        // Reset while a read is outstanding, with ack arriving on the same edge.
        @(posedge clk); #1;
        mem_read_i = 1; ir_write_i = 1; pc_i = 12'h055;
        @(negedge clk);
        @(negedge clk);
        check("rst_req.req_up", 32'(mem_req_o), 32'd1);
        rst = 1; mem_ack_i = 1; mem_rdata_i = 16'h4444;
        @(negedge clk);
        check("rst_req.req_drop", 32'(mem_req_o), 32'd0);
        check("rst_req.ir",  32'(ir_o),  32'd0);
        check("rst_req.mdr", 32'(mdr_o), 32'd0);
        check("rst_req.err", 32'(err_o), 32'd0);
        rst = 0; mem_ack_i = 0;
        clear_inputs();
        @(negedge clk);
        check("rst_req.idle", 32'({mem_req_o, busy_o}), 32'd0);

`ifdef MEMIF_TIMEOUT_EN
        begin
            int req_cycles = 0;
            bit ended = 0;
            @(posedge clk); #1;
            mem_read_i = 1; iord_i = 1; addr_i = 12'h333;
            for (int c = 0; c < 40 && !ended; c++) begin
                @(negedge clk);
                if (mem_req_o) req_cycles++;
                else if (req_cycles > 0) ended = 1;
            end
            check("timeout.ended", 32'(ended), 32'd1);
            check("timeout.req_cycles", 32'(req_cycles), 32'd8);
            check("timeout.err", 32'(err_o), 32'd1);
            check("timeout.busy_done", 32'(busy_o), 32'd0);
            @(posedge clk); #1;
            clear_inputs();
            @(negedge clk);
            check("timeout.idle", 32'({mem_req_o, busy_o}), 32'd0);
            check("timeout.sticky", 32'(err_o), 32'd1);
            check("timeout.mdr", 32'(mdr_o), 32'd0);
            // A new request then reset mid-REQ clears the flag.
            @(posedge clk); #1;
            mem_read_i = 1;
            @(negedge clk);
            @(negedge clk);
            rst = 1;
            @(negedge clk);
            check("timeout.rst_req", 32'(mem_req_o), 32'd0);
            check("timeout.rst_err", 32'(err_o), 32'd0);
            rst = 0;
            clear_inputs();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multicycle control unit.
- Turns the per-state strobes (MemRead, MemWrite, IorD, IRWrite) into a req/ack transaction on a variable-latency 16-bit memory port.
- Latches fetched words into the instruction register (IR) or memory data register (MDR).
- Raises busy_o so the control unit holds its current state until the access completes.

Parameters:
- DATA_W, 16, memory/instruction word width
- ADDR_W, 12, word address width
- TIMEOUT_CYCLES, 255, maximum REQ cycles before abort (only with MEMIF_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_read_i  in  1  MemRead strobe from control unit
- mem_write_i  in  1  MemWrite strobe from control unit
- iord_i  in  1  address select: 0 = pc_i, 1 = addr_i
- ir_write_i  in  1  IRWrite; read data targets IR instead of MDR
- pc_i  in  ADDR_W  program counter
- addr_i  in  ADDR_W  data address from datapath
- wdata_i  in  DATA_W  store data
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write transaction
- mem_addr_o  out  ADDR_W  transaction address
- mem_wdata_o  out  DATA_W  transaction write data
- mem_rdata_i  in  DATA_W  read data, valid with ack
- mem_ack_i  in  1  transaction complete
- ir_o  out  DATA_W  instruction register
- mdr_o  out  DATA_W  memory data register
- busy_o  out  1  stall to control unit
- err_o  out  1  sticky timeout flag

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high; all state changes on rising clk.
- Reset values: state IDLE; mem_req_o, mem_we_o, busy_o, err_o = 0; mem_addr_o, mem_wdata_o, ir_o, mdr_o = 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - cmd = mem_read_i | mem_write_i.
  - busy_o = cmd (combinational).
  - If cmd, register address (iord_i ? addr_i : pc_i), we = mem_write_i, wdata_i, and destination (ir_write_i & ~mem_write_i); go to REQ.
- Simultaneous read and write strobes: write wins, read is dropped.
- ir_write_i without mem_read_i: ignored.
- REQ:
  - mem_req_o = 1 (registered); busy_o = 1; address, we and wdata held stable.
  - On mem_ack_i: for a read, load mem_rdata_i into ir_o (dest IR) or mdr_o (dest MDR); the other register is unchanged. Go to DONE.
- DONE:
  - mem_req_o = 0; busy_o = 0; strobes ignored this cycle, because the control unit is still in the same state; go to IDLE.
- Latency: command in cycle T, earliest ack T+1, result visible in ir_o/mdr_o at T+2, busy_o high T..T+1.
- ir_o/mdr_o change only on an acked read; a write never alters them.
- mem_ack_i outside REQ is ignored.
- rst during REQ aborts the transaction: mem_req_o drops the next cycle, no register update.

Optional Feature:
- Macro MEMIF_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entering REQ and increments each REQ cycle without ack.
  - On reaching TIMEOUT_CYCLES: set err_o (sticky until rst), drop mem_req_o, go to DONE with no IR/MDR update.
- Undefined: REQ waits indefinitely; err_o tied 0; no counter logic.

Decomposition:
- Package memif_pkg: state enum (IDLE, REQ, DONE), DATA_W/ADDR_W defaults, destination encoding (DEST_IR, DEST_MDR).
- Optional sub-module memif_watchdog: the timeout counter, instantiated only under MEMIF_TIMEOUT_EN.
- The remaining logic stays in one module.

Test Plan:
- Reset then idle → all outputs 0, busy_o 0, mem_req_o 0 for 10 cycles.
- Fetch: mem_read_i=1, ir_write_i=1, iord_i=0, pc_i=0x010, memory acks 1 cycle after req with 0x8003 → mem_addr_o=0x010, ir_o=0x8003, mdr_o unchanged, busy_o high exactly 2 cycles.
- Load: iord_i=1, addr_i=0x0A5, ack after 4 wait cycles with 0x1234 → mdr_o=0x1234, ir_o unchanged, busy_o high 5 cycles.
- Store plus read conflict: mem_write_i=1, mem_read_i=1, wdata_i=0xBEEF, addr 0x0FF → mem_we_o=1, mem_wdata_o=0xBEEF, neither ir_o nor mdr_o changes.
- Strobes held through DONE → exactly one transaction issued; spurious mem_ack_i in IDLE → no effect.
- With MEMIF_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack → err_o=1 after 8 REQ cycles, mem_req_o=0, returns to IDLE; rst mid-REQ → mem_req_o=0 the next cycle, err_o cleared.
